ripple_count_ctrl: RTL and testbench
====================================

// Module: ripple_count_ctrl
// PURPOSE
//  Synchronous controller that sequences an external W-bit asynchronous ripple counter.
//  - Generates the counter's tick clock and reset.
//  - Reads the counter back through a synchronizer after ripple settling.
//  - Checks each sample against an internal shadow count.
//  - Stops at a programmable target.
//  Sits between the control logic on Clock and the ripple counter it owns.
// PARAMETERS
//  W              3  counter width (bits of cnt_q/count/target)
//  DIV_W          8  width of tick_div
//  SETTLE_CYCLES  2  Clock cycles allowed for ripple settling after a tick's falling edge
//  RST_CYCLES     2  Clock cycles cnt_rst is held in CLEAR
// PORTS
//  Clock     in   1      system clock, all state on posedge
//  Reset     in   1      reset, asynchronous, active-high
//  start     in   1      pulse: begin counting run (IDLE only)
//  stop      in   1      pulse/level: end run at next CHECK
//  clear     in   1      pulse: abort, reset counter, clear err/count
//  target    in   W      stop value; 0 = free-run until stop
//  tick_div  in   DIV_W  cnt_tick high time in Clock cycles; 0 treated as 1
//  cnt_q     in   W      ripple counter output (asynchronous to Clock)
//  cnt_tick  out  1      clock to ripple counter; counter advances on its falling edge
//  cnt_rst   out  1      reset to ripple counter, active-high
//  count     out  W      last verified counter value
//  busy      out  1      1 in every state except IDLE and ERROR
//  done      out  1      1-cycle pulse when count reaches a non-zero target
//  err       out  1      sticky: sampled value != expected value
// BEHAVIOUR
//  - Reset (async): state=CLEAR, cnt_tick=0, count=0, shadow=0, done=0, err=0, timer=0.
//    - cnt_rst=1 combinationally while Reset=1.
//  - cnt_tick is registered, glitch-free, 1 only in HIGH.
//  - cnt_rst is registered (OR Reset), 1 only in CLEAR.
//  - CLEAR: hold cnt_rst for RST_CYCLES cycles; shadow=0, count=0, err=0 -> IDLE.
//  - IDLE: start&!stop -> HIGH. start&stop in the same cycle: stop wins, stay IDLE.
//    stop alone: ignored.
//  - HIGH: cnt_tick=1 for max(tick_div,1) cycles -> LOW. The falling edge increments the counter.
//  - LOW: cnt_tick=0 for SETTLE_CYCLES+2 cycles (settle + 2-flop sync) -> CHECK.
//  - CHECK (1 cycle): exp=(shadow+1) mod 2^W; compare the synchronized sample s to exp.
//    - s!=exp: err<=1 -> ERROR. count is not updated.
//    - s==exp: shadow<=s, count<=s; then
//      - target!=0 && s==target: done=1 for this cycle -> IDLE.
//      - else stop latched -> IDLE.
//      - else -> HIGH.
//  - stop: latched when seen in HIGH/LOW/CHECK; acts only at CHECK, so a tick is never
//    truncated. The latch is cleared on leaving CHECK.
//  - Wrap: 2^W-1 -> 0 is legal, with no err. target is compared exactly, so with target=0
//    the run never ends on wrap.
//  - ERROR: cnt_tick=0, err=1, busy=0; leave only via clear or Reset.
//  - clear: in any state -> CLEAR next cycle, overriding start/stop. Mid-HIGH, cnt_tick
//    drops; that extra falling edge is harmless because the counter is reset.
//  - start while busy: ignored. target and tick_div are sampled live; change them only in IDLE.
//  - Reset mid-operation: immediate return to the reset values above, then CLEAR.
//  - Width rule: all count arithmetic is W bits, mod 2^W. The timer is DIV_W bits.
// STRUCTURE
//  - Shared package/header ripple_ctrl_defs: state encoding
//    (CLEAR, IDLE, HIGH, LOW, CHECK, ERROR), default W, SETTLE_CYCLES, RST_CYCLES.
//  - Sub-module sync_bus #(W): 2-flop synchronizer on cnt_q, async reset to 0.
//  - Top: FSM, down-timer, shadow/count registers, stop latch.
// TESTING  (bench includes a behavioural ripple-counter model driven by cnt_tick/cnt_rst)
//  1. Reset, start with target=5, tick_div=1 -> 5 falling edges on cnt_tick, count=5,
//     done high for 1 cycle, busy=0, err=0.
//  2. target=0, W=3, run 9 ticks -> count goes 6,7,0,1 with no err; stop asserted mid-HIGH
//     -> that tick completes, count=1, IDLE.
//  3. Model bit1 stuck at 0 -> at the 2nd CHECK expected 2, sampled 0 -> err=1, state ERROR,
//     cnt_tick=0. Then clear -> cnt_rst high 2 cycles, err=0, count=0, IDLE.
//  4. Reset asserted mid-HIGH -> same cycle cnt_tick=0 and cnt_rst=1; count=0.
//     After release, cnt_rst stays high RST_CYCLES, then IDLE.
//  5. start&stop in the same cycle in IDLE -> stays IDLE.
//     start pulsed during a run -> no effect on tick count.
//  6. tick_div=0 -> cnt_tick high 1 cycle; tick_div=3 -> high 3 cycles.
//     Low time is always SETTLE_CYCLES+3 cycles including CHECK.

Source files
------------

// File: rtl/ripple_ctrl_defs.sv
// Shared definitions for the ripple-counter controller: state encoding and
// default geometry of the external counter and its timing windows.
package ripple_ctrl_defs;

  localparam int unsigned W_DEF             = 3;
  localparam int unsigned SETTLE_CYCLES_DEF = 2;
  localparam int unsigned RST_CYCLES_DEF    = 2;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    HIGH,
    LOW,
    CHECK,
    ERROR
  } state_e;

endpackage

// File: rtl/sync_bus.sv
// Two-flop synchronizer that brings the free-running ripple counter value
// into the Clock domain; only sampled once the ripple has settled.
module sync_bus #(
  parameter int unsigned W = 3
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a two-stage chain.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ripple_count_ctrl.sv
// Sequences an external asynchronous ripple counter: drives its tick and reset,
// reads it back after settling and checks every sample against a shadow count.
module ripple_count_ctrl
  import ripple_ctrl_defs::*;
#(
  parameter int unsigned W             = W_DEF,
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [W-1:0]     target,
  input  logic [DIV_W-1:0] tick_div,
  input  logic [W-1:0]     cnt_q,
  output logic             cnt_tick,
  output logic             cnt_rst,
  output logic [W-1:0]     count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Timer holds elapsed cycles in the current state; these are the last indices.
  localparam logic [DIV_W-1:0] RST_LAST = DIV_W'(RST_CYCLES - 1);
  localparam logic [DIV_W-1:0] LOW_LAST = DIV_W'(SETTLE_CYCLES + 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic [W-1:0]     count_q, count_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tick_q;
  logic             rst_q;

  logic [W-1:0]     sample;
  logic [W-1:0]     expected;
  logic [DIV_W-1:0] high_last;
  logic             stop_seen;

  sync_bus #(.W(W)) u_sync (
    .Clock (Clock),
    .Reset (Reset),
    .d_i   (cnt_q),
    .q_o   (sample)
  );

  assign high_last = (tick_div == '0) ? '0 : tick_div - DIV_W'(1);
  assign expected  = shadow_q + W'(1);
  assign stop_seen = stop_q | stop;

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    stop_d   = stop_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      CLEAR: begin
        timer_d  = timer_q + DIV_W'(1);
        shadow_d = '0;
        count_d  = '0;
        err_d    = 1'b0;
        stop_d   = 1'b0;
        if (timer_q >= RST_LAST) state_d = IDLE;
      end
      IDLE: begin
        if (start && !stop) state_d = HIGH;
      end
      HIGH: begin
        timer_d = timer_q + DIV_W'(1);
        stop_d  = stop_seen;
        if (timer_q >= high_last) state_d = LOW;
      end
      LOW: begin
        timer_d = timer_q + DIV_W'(1);
        stop_d  = stop_seen;
        if (timer_q >= LOW_LAST) state_d = CHECK;
      end
      CHECK: begin
        stop_d = 1'b0;
        if (sample != expected) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          shadow_d = sample;
          count_d  = sample;
          if ((target != '0) && (sample == target)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (stop_seen) begin
            state_d = IDLE;
          end else begin
            state_d = HIGH;
          end
        end
      end
      ERROR: begin
      end
      default: state_d = CLEAR;
    endcase

    if (clear) begin
      state_d = CLEAR;
      done_d  = 1'b0;
      stop_d  = 1'b0;
    end

    // Each state times itself from zero; a repeated clear restarts CLEAR.
    if ((state_d != state_q) || clear) timer_d = '0;
  end

  // Tick and counter reset are flops decoded from the next state, so both
  // outputs are glitch-free and line up exactly with the state they belong to.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= CLEAR;
      timer_q  <= '0;
      shadow_q <= '0;
      count_q  <= '0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tick_q   <= 1'b0;
      rst_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tick_q   <= (state_d == HIGH);
      rst_q    <= (state_d == CLEAR);
    end
  end

  assign cnt_tick = tick_q;
  assign cnt_rst  = rst_q | Reset;
  assign count    = count_q;
  assign busy     = (state_q != IDLE) && (state_q != ERROR);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Directed bench for ripple_count_ctrl with a behavioural ripple counter
// clocked by the falling edge of cnt_tick and cleared by cnt_rst.
module tb_ripple_count_ctrl;

  localparam int W     = 3;
  localparam int DIV_W = 8;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             start;
  logic             stop;
  logic             clear;
  logic [W-1:0]     target;
  logic [DIV_W-1:0] tick_div;
  logic [W-1:0]     cnt_q;
  logic             cnt_tick;
  logic             cnt_rst;
  logic [W-1:0]     count;
  logic             busy;
  logic             done;
  logic             err;

  logic [W-1:0]     model_q;
  logic [W-1:0]     stuck_mask;

  int checks   = 0;
  int failures = 0;
  int falls    = 0;
  int run_len  = 0;
  int last_hi  = 0;
  int last_lo  = 0;
  int f0;
  logic prev_tick = 1'b0;

  ripple_count_ctrl dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .target   (target),
    .tick_div (tick_div),
    .cnt_q    (cnt_q),
    .cnt_tick (cnt_tick),
    .cnt_rst  (cnt_rst),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 Clock = ~Clock;

  // Ripple counter model; a stuck bit is modelled on the output pins.
  always @(negedge cnt_tick or posedge cnt_rst) begin
    if (cnt_rst) model_q <= '0;
    else         model_q <= model_q + 3'd1;
  end
  assign cnt_q = model_q & ~stuck_mask;

  always @(negedge cnt_tick) falls++;

  // Run-length monitor: at each posedge cnt_tick still holds the value of the cycle just ended.
  always @(posedge Clock) begin
    if (cnt_tick === prev_tick) begin
      run_len++;
    end else begin
      if (prev_tick) last_hi = run_len;
      else           last_lo = run_len;
      run_len = 1;
    end
    prev_tick = cnt_tick;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic wait_tick(input logic val, input string tag);
    int n = 0;
    while (cnt_tick !== val && n < 300) begin
      step(1);
      n++;
    end
    check({tag, "_timeout"}, 32'(cnt_tick === val), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      step(1);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    clear      = 1'b0;
    target     = '0;
    tick_div   = 8'd1;
    stuck_mask = '0;

    // ---- reset values ----
    #1;
    check("rst_cnt_tick", 32'(cnt_tick), 32'd0);
    check("rst_cnt_rst",  32'(cnt_rst),  32'd1);
    check("rst_count",    32'(count),    32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    step(2);
    Reset = 1'b0;
    step(1);
    check("rel_cnt_rst_c1", 32'(cnt_rst), 32'd1);
    check("rel_busy_c1",    32'(busy),    32'd1);
    step(1);
    check("rel_cnt_rst_c2", 32'(cnt_rst), 32'd0);
    check("rel_busy_idle",  32'(busy),    32'd0);

    // ---- 1: target=5, tick_div=1 ----
    target = 3'd5;
    f0 = falls;
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    wait_idle("t1");
    check("t1_done",  32'(done),   32'd1);
    check("t1_count", 32'(count),  32'd5);
    check("t1_err",   32'(err),    32'd0);
    check("t1_falls", 32'(falls - f0), 32'd5);
    step(1);
    check("t1_done_pulse_end", 32'(done), 32'd0);

    // ---- 2: free run through wrap, stop mid-HIGH ----
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(2);
    check("t2_clear_idle",  32'(busy),  32'd0);
    check("t2_clear_count", 32'(count), 32'd0);
    target   = 3'd0;
    tick_div = 8'd2;
    f0 = falls;
    pulse_start();
    for (int i = 1; i <= 9; i++) begin
      wait_tick(1'b1, "t2_rise");
      check("t2_count_at_tick", 32'(count), 32'((i - 1) % 8));
      if (i == 9) begin
        stop = 1'b1;
        step(1);
        stop = 1'b0;
      end
      wait_tick(1'b0, "t2_fall");
    end
    wait_idle("t2");
    check("t2_count", 32'(count), 32'd1);
    check("t2_falls", 32'(falls - f0), 32'd9);
    check("t2_err",   32'(err),  32'd0);
    check("t2_done",  32'(done), 32'd0);
    step(6);
    check("t2_no_more_ticks", 32'(falls - f0), 32'd9);

    // ---- 3: bit1 stuck at 0 -> ERROR, then clear ----
    stuck_mask = 3'b010;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(2);
    tick_div = 8'd1;
    f0 = falls;
    pulse_start();
    wait_idle("t3");
    check("t3_err",      32'(err),      32'd1);
    check("t3_count",    32'(count),    32'd1);
    check("t3_cnt_tick", 32'(cnt_tick), 32'd0);
    check("t3_falls",    32'(falls - f0), 32'd2);
    pulse_start();
    step(4);
    check("t3_err_sticky",     32'(err),  32'd1);
    check("t3_start_ignored",  32'(busy), 32'd0);
    check("t3_no_tick",        32'(falls - f0), 32'd2);
    stuck_mask = '0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t3_clr_rst_c1", 32'(cnt_rst), 32'd1);
    step(1);
    check("t3_clr_rst_c2", 32'(cnt_rst), 32'd1);
    check("t3_clr_err",    32'(err),     32'd0);
    step(1);
    check("t3_clr_rst_end", 32'(cnt_rst), 32'd0);
    check("t3_clr_count",   32'(count),   32'd0);
    check("t3_clr_idle",    32'(busy),    32'd0);

    // ---- 4: Reset mid-HIGH ----
    tick_div = 8'd10;
    target   = 3'd0;
    pulse_start();
    wait_tick(1'b1, "t4_rise1");
    wait_tick(1'b0, "t4_fall1");
    wait_tick(1'b1, "t4_rise2");
    check("t4_count_before", 32'(count), 32'd1);
    step(3);
    #2 Reset = 1'b1;
    #1;
    check("t4_cnt_tick", 32'(cnt_tick), 32'd0);
    check("t4_cnt_rst",  32'(cnt_rst),  32'd1);
    check("t4_count",    32'(count),    32'd0);
    step(1);
    Reset = 1'b0;
    step(1);
    check("t4_rel_rst_c1", 32'(cnt_rst), 32'd1);
    step(1);
    check("t4_rel_rst_end", 32'(cnt_rst),  32'd0);
    check("t4_rel_idle",    32'(busy),     32'd0);
    tick_div = 8'd1;

    // ---- 5: start&stop together; start during a run ----
    f0 = falls;
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check("t5_startstop_idle", 32'(busy), 32'd0);
    step(3);
    check("t5_startstop_still_idle", 32'(busy), 32'd0);
    check("t5_startstop_no_tick",    32'(falls - f0), 32'd0);
    target = 3'd3;
    pulse_start();
    wait_tick(1'b1, "t5_rise");
    step(2);
    pulse_start();
    wait_idle("t5");
    check("t5_done",  32'(done),  32'd1);
    check("t5_count", 32'(count), 32'd3);
    check("t5_falls", 32'(falls - f0), 32'd3);

    // ---- 6: tick high/low widths ----
    target   = 3'd0;
    tick_div = 8'd0;
    pulse_start();
    wait_tick(1'b1, "t6a_rise1");
    wait_tick(1'b0, "t6a_fall1");
    wait_tick(1'b1, "t6a_rise2");
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("t6a_high_width", 32'(last_hi), 32'd1);
    check("t6a_low_width",  32'(last_lo), 32'd5);
    wait_idle("t6a");
    check("t6a_count", 32'(count), 32'd5);
    tick_div = 8'd3;
    pulse_start();
    wait_tick(1'b1, "t6b_rise1");
    wait_tick(1'b0, "t6b_fall1");
    wait_tick(1'b1, "t6b_rise2");
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("t6b_high_width", 32'(last_hi), 32'd3);
    check("t6b_low_width",  32'(last_lo), 32'd5);
    wait_idle("t6b");
    check("t6b_count", 32'(count), 32'd7);
    check("t6b_err",   32'(err),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
